// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler
//   Shares the single write port of an external flag-less fifo between
//   NUM_REQ requesters using round-robin arbitration. It also gates consumer
//   pops and owns the occupancy count, so the fifo is never written when full
//   or read when empty. A flush pulse drains and discards the fifo contents.
//
// Optional build macro: FIFO_SCHED_STATS_EN adds the blocked_cycles and
// push_total statistics outputs.
//
// Ports:
//   clk            clock; all state updates on posedge
//   rst            synchronous active-low reset
//   req            per-requester push request, held with data until granted
//   req_data       packed data, requester i at [i*ITEM_SIZE +: ITEM_SIZE]
//   grant          one-hot combinational grant
//   pop_req        consumer requests one item
//   pop_valid      registered; fifo data_out holds the popped item
//   flush          single-cycle pulse; drain and discard fifo contents
//   fifo_write_en  fifo write_en, equals |grant
//   fifo_read_en   fifo read_en
//   fifo_data_in   fifo data_in, granted slice or 0
//   fifo_rst       fifo rst (active-high), equals ~rst
//   count          current occupancy
//   full, empty    occupancy flags
//   blocked_cycles RUN cycles with a request blocked by full (stats build)
//   push_total     number of fifo writes (stats build)
//   busy           a flush is draining the fifo
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal operation: arbitrate pushes, serve consumer pops
// S_FLUSH | drain fifo with reads every cycle, no grants, no pop_valid

module fifo_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ITEM_SIZE   = 8,
  parameter int BUFFER_SIZE = 8,
  parameter int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ITEM_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  input  logic                         pop_req,
  output logic                         pop_valid,
  input  logic                         flush,
  output logic                         fifo_write_en,
  output logic                         fifo_read_en,
  output logic [ITEM_SIZE-1:0]         fifo_data_in,
  output logic                         fifo_rst,
  output logic [CNT_W-1:0]             count,
  output logic                         full,
  output logic                         empty,
`ifdef FIFO_SCHED_STATS_EN
  output logic [15:0]                  blocked_cycles,
  output logic [15:0]                  push_total,
`endif
  output logic                         busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_hit;
  logic               grant_en;
  logic               in_run;
  logic [CNT_W-1:0]   count_next;

  assign full     = (count == CNT_W'(BUFFER_SIZE));
  assign empty    = (count == '0);
  assign fifo_rst = ~rst;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    int idx;
    grant_idx = '0;
    grant_hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_hit && req[idx]) begin
        grant_hit = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    int nxt;
    nxt         = (int'(grant_idx) + 1) % NUM_REQ;
    rr_ptr_next = PTR_W'(nxt);
  end

  // Output process: grants, read gating and status.
  always_comb begin
    in_run   = (state == S_RUN);
    busy     = (state == S_FLUSH);
    // A write at full is refused even when a pop frees a slot on the same
    // edge; the fifo's behaviour in that corner is not relied on.
    grant_en = rst & in_run & grant_hit & ~full;
    grant    = '0;
    if (grant_en) grant[grant_idx] = 1'b1;
    fifo_write_en = grant_en;
    fifo_data_in  = grant_en ? req_data[int'(grant_idx)*ITEM_SIZE +: ITEM_SIZE]
                             : '0;
    fifo_read_en  = rst & ~empty & (busy | pop_req);
    count_next    = count + CNT_W'(fifo_write_en) - CNT_W'(fifo_read_en);
  end

  // Next-state process.
  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (flush) state_next = S_FLUSH;
      S_FLUSH: if (empty || count_next == '0) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RUN;
      rr_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      pop_valid <= fifo_read_en & in_run;
      if (fifo_write_en) rr_ptr <= rr_ptr_next;
    end
  end

`ifdef FIFO_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      blocked_cycles <= '0;
      push_total     <= '0;
    end else begin
      if (in_run && (|req) && full && blocked_cycles != 16'hFFFF)
        blocked_cycles <= blocked_cycles + 16'd1;
      if (fifo_write_en && push_total != 16'hFFFF)
        push_total <= push_total + 16'd1;
    end
  end
`endif

endmodule
